// File: rtl/mips_bus_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single Avalon
// master. One transaction at a time; round-robin on ties; a wait counter
// aborts transactions stuck on waitrequest and raises a sticky bus_error.
//
// Handshake: a requester raises *_req with its address/data stable and keeps
// them stable until its *_done pulses for one cycle; on the bus side, the
// granted read/write and its qualifiers stay stable while waitrequest=1 and
// the transfer completes on the first edge that sees waitrequest=0.
module mips_bus_arbiter #(
  parameter int WAIT_LIMIT  = 16,
  parameter bit FIRST_GRANT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  // instruction fetch port
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_done,
  output logic [31:0] i_rdata,
  // data port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteenable,
  output logic        d_done,
  output logic [31:0] d_rdata,
  // Avalon master
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata,
  input  logic        waitrequest,
  // status / debug
  output logic        bus_error,
  output logic [1:0]  dbg_state
);

  localparam int CW = $clog2(WAIT_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   address_q, address_d;
  logic          read_q, read_d;
  logic          write_q, write_d;
  logic [31:0]   writedata_q, writedata_d;
  logic [3:0]    byteenable_q, byteenable_d;
  logic          i_done_q, i_done_d;
  logic          d_done_q, d_done_d;
  logic [31:0]   i_rdata_q, i_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;
  logic          bus_error_q, bus_error_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  // 1: data wins the next tie, 0: instruction wins the next tie
  logic          prio_d_q, prio_d_d;
  logic          grant_d, grant_i;

  // Next-state, grant and completion logic; everything defaults to hold.
  always_comb begin
    state_d      = state_q;
    address_d    = address_q;
    read_d       = read_q;
    write_d      = write_q;
    writedata_d  = writedata_q;
    byteenable_d = byteenable_q;
    i_done_d     = 1'b0;
    d_done_d     = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    bus_error_d  = bus_error_q;
    wait_cnt_d   = wait_cnt_q;
    prio_d_d     = prio_d_q;
    grant_d      = 1'b0;
    grant_i      = 1'b0;
    case (state_q)
      IDLE: begin
        grant_d = d_req && (!i_req || prio_d_q);
        grant_i = i_req && !grant_d;
        if (grant_d) begin
          state_d      = BUSY_D;
          address_d    = d_addr;
          writedata_d  = d_wdata;
          byteenable_d = d_byteenable;
          read_d       = !d_we;
          write_d      = d_we;
          wait_cnt_d   = '0;
          prio_d_d     = 1'b0;
        end else if (grant_i) begin
          state_d      = BUSY_I;
          address_d    = i_addr;
          byteenable_d = 4'b1111;
          read_d       = 1'b1;
          write_d      = 1'b0;
          wait_cnt_d   = '0;
          prio_d_d     = 1'b1;
        end
      end
      BUSY_I, BUSY_D: begin
        if (!waitrequest) begin
          // normal completion: capture read data for the owner and pulse done
          read_d  = 1'b0;
          write_d = 1'b0;
          state_d = IDLE;
          if (state_q == BUSY_I) begin
            i_done_d = 1'b1;
            if (read_q) i_rdata_d = readdata;
          end else begin
            d_done_d = 1'b1;
            if (read_q) d_rdata_d = readdata;
          end
        end else if (wait_cnt_q == CW'(WAIT_LIMIT - 1)) begin
          // this is the WAIT_LIMIT-th stalled cycle: abandon the transfer
          read_d      = 1'b0;
          write_d     = 1'b0;
          bus_error_d = 1'b1;
          wait_cnt_d  = wait_cnt_q + CW'(1);
          state_d     = IDLE;
          if (state_q == BUSY_I) begin
            i_done_d  = 1'b1;
            i_rdata_d = '0;
          end else begin
            d_done_d  = 1'b1;
            d_rdata_d = '0;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      address_q    <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      writedata_q  <= '0;
      byteenable_q <= '0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      bus_error_q  <= 1'b0;
      wait_cnt_q   <= '0;
      prio_d_q     <= FIRST_GRANT;
    end else begin
      state_q      <= state_d;
      address_q    <= address_d;
      read_q       <= read_d;
      write_q      <= write_d;
      writedata_q  <= writedata_d;
      byteenable_q <= byteenable_d;
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      bus_error_q  <= bus_error_d;
      wait_cnt_q   <= wait_cnt_d;
      prio_d_q     <= prio_d_d;
    end
  end

  assign address    = address_q;
  assign read       = read_q;
  assign write      = write_q;
  assign writedata  = writedata_q;
  assign byteenable = byteenable_q;
  assign i_done     = i_done_q;
  assign d_done     = d_done_q;
  assign i_rdata    = i_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign bus_error  = bus_error_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/mips_bus_arbiter.md
MIPS_BUS_ARBITER -- requirements
Module: mips_bus_arbiter

Interface
Parameters:
REQ-001 The block SHALL have parameter WAIT_LIMIT, default 16: the maximum number of consecutive waitrequest-high cycles before a transaction is aborted.
REQ-002 The block SHALL have parameter FIRST_GRANT, default 1: the port that wins a tie after reset (1 = data, 0 = instruction).

Ports:
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have instruction-fetch port inputs i_req (1), i_addr (32).
REQ-006 The block SHALL have instruction-fetch port outputs i_done (1), i_rdata (32).
REQ-007 The block SHALL have data port inputs d_req (1), d_we (1), d_addr (32), d_wdata (32), d_byteenable (4).
REQ-008 The block SHALL have data port outputs d_done (1), d_rdata (32).
REQ-009 The block SHALL have Avalon master outputs address (32), read (1), write (1), writedata (32), byteenable (4).
REQ-010 The block SHALL have Avalon master inputs readdata (32), waitrequest (1).
REQ-011 The block SHALL have output bus_error, 1 bit: sticky flag set on a WAIT_LIMIT abort.

Function
REQ-012 The state machine SHALL have three states: IDLE, BUSY_I, BUSY_D.
REQ-013 The block SHALL register all master outputs; it SHALL NOT drive any combinational path from a requester input to the bus.
REQ-014 In IDLE with exactly one request high, the block SHALL grant that requester and move to its BUSY state on the next edge.
REQ-015 In IDLE with both requests high, the block SHALL grant the port not granted last (round-robin); after reset, the port named by FIRST_GRANT wins.
REQ-016 On grant, the block SHALL latch the address, data and enables into the master outputs.
REQ-017 On instruction grant, the block SHALL set read=1 and byteenable=4'b1111.
REQ-018 On data grant, the block SHALL set read=!d_we and write=d_we.
REQ-019 In a BUSY state, the block SHALL hold all master outputs stable while waitrequest=1.
REQ-020 On the first BUSY edge with waitrequest=0, the block SHALL:
- drop read and write;
- for a read, capture readdata into the granted i_rdata or d_rdata;
- pulse the granted done for exactly one cycle;
- return to IDLE.
REQ-021 The minimum transaction SHALL be 3 cycles from req to the done pulse: grant edge, bus cycle, done edge.
REQ-022 Back-to-back transactions SHALL have exactly one IDLE cycle between them.
REQ-023 A write SHALL leave d_rdata unchanged.
REQ-024 The i_rdata and d_rdata registers SHALL hold their value until the next completed read on that port.
REQ-025 Requesters SHALL hold req and their inputs until done. If req drops mid-transaction, the transaction SHALL still complete and done SHALL still pulse.
REQ-026 A req still high in the cycle after done SHALL be treated as a new request.
REQ-027 A wait counter SHALL count consecutive waitrequest-high cycles in BUSY and SHALL clear on every grant.
REQ-028 When the wait counter reaches WAIT_LIMIT, the block SHALL:
- drop read and write;
- set bus_error;
- write 0 to the granted rdata;
- pulse done;
- return to IDLE.
REQ-029 bus_error SHALL stay set until reset.
REQ-030 No master output SHALL change while waitrequest=1, except on a WAIT_LIMIT abort.
REQ-031 read and write SHALL never both be 1.
REQ-032 i_done and d_done SHALL never both be 1 in the same cycle.

Reset
REQ-033 While reset=0, the block SHALL immediately and asynchronously:
- set state to IDLE;
- clear read, write, address, writedata, byteenable;
- clear i_done, d_done, i_rdata, d_rdata;
- clear bus_error and the wait counter;
- reset the round-robin pointer so the FIRST_GRANT port wins.
REQ-034 If reset asserts mid-transaction, the block SHALL drop the bus at once with no done pulse; the transaction is lost.
REQ-035 The first grant SHALL occur no earlier than the first rising edge after reset rises.

Verification
REQ-036 Single fetch: i_req, i_addr=32'hBFC00000, waitrequest=0, readdata=32'h8C020004 -> read=1 for 1 cycle, byteenable=4'hF; i_rdata=32'h8C020004 with i_done on cycle 3.
REQ-037 Data write with waits: d_we=1, d_addr=32'h00001000, d_wdata=32'hDEADBEEF, d_byteenable=4'b0011, waitrequest high 2 cycles -> write held 3 cycles with stable outputs; d_done pulses once; d_rdata unchanged.
REQ-038 Contention: i_req and d_req held high from reset -> grants D, I, D, I alternating, one IDLE cycle apart.
REQ-039 Timeout: WAIT_LIMIT=4, waitrequest stuck at 1 on a fetch -> read drops after 4 wait cycles; i_done pulses; i_rdata=0; bus_error=1 until reset.
REQ-040 Reset mid-operation: reset=0 while in BUSY_D with waitrequest=1 -> write=0 with no clock edge; no d_done; after release with both requests high, data is granted first.
